// File: rtl/lc3b_types.sv
// Shared types and constants for the LC-3b L1 cache datapath and controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package lc3b_types;

    // Set index for an 8-set cache and one 128-bit cache line / pmem burst.
    typedef logic [2:0]   lc3b_set;
    typedef logic [127:0] lc3b_burst;

    // Cache controller states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } cache_state_t;

    // Data array write-source select.
    localparam logic DSEL_CPU     = 1'b0;  // CPU-merged line (write hit)
    localparam logic DSEL_PMEM    = 1'b1;  // incoming pmem burst (fill)

    // pmem address select.
    localparam logic PADDR_CPU    = 1'b0;  // CPU tag:set (allocate)
    localparam logic PADDR_VICTIM = 1'b1;  // victim tag:set (writeback)

endpackage

// File: rtl/lru_array.sv
// Per-set LRU bit store: one bit per set naming the way to evict next.
// Latency: combinational read at idx_i; write takes effect at the next clk edge.
// Backpressure: none; a write is accepted every cycle we_i is high.
//
// Ports:
//   clk, rst   - clock and asynchronous active-high reset (clears every bit)
//   we_i       - write enable for the entry at idx_i
//   idx_i      - set index for both read and write
//   wdata_i    - new LRU bit
//   rdata_o    - current LRU bit at idx_i
module lru_array
    import lc3b_types::*;
#(
    parameter int NUM_SETS = 8
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    we_i,
    input  lc3b_set idx_i,
    input  logic    wdata_i,
    output logic    rdata_o
);

    logic [NUM_SETS-1:0] lru_bits_q;
    logic [NUM_SETS-1:0] lru_bits_d;

    always_comb begin
        lru_bits_d = lru_bits_q;
        if (we_i) begin
            lru_bits_d[idx_i] = wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lru_bits_q <= '0;
        end else begin
            lru_bits_q <= lru_bits_d;
        end
    end

    assign rdata_o = lru_bits_q[idx_i];

endmodule

// File: rtl/cache_control.sv
// Controller for the 2-way set-associative L1: hit handling, victim writeback, line allocate.
// Latency: hits complete in the request cycle; a miss completes one cycle after the last pmem_resp.
// Backpressure: CPU request is held until mem_resp; pmem strobes are held until pmem_resp.
//
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   mem_read/mem_write       - CPU request (write wins if both); mem_resp completes it
//   set                      - set index of the request, stable while a request is up
//   tag0_hit/tag1_hit        - valid-qualified tag matches (way0 wins if both)
//   valid0/1, dirty0/1       - status bits of both ways at set
//   lru                      - victim way at set
//   data_load/data_sel       - data array write strobe and write source
//   tag_load/valid_set       - load CPU tag / set valid in the victim way
//   dirty_set/dirty_clear    - set dirty in the hit way / clear dirty in the victim way
//   pmem_read/pmem_write     - pmem burst requests; pmem_resp ends a burst
//   pmem_addr_sel            - pmem address source (CPU tag:set or victim tag:set)
module cache_control
    import lc3b_types::*;
#(
    parameter int NUM_SETS = 8
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    mem_read,
    input  logic    mem_write,
    output logic    mem_resp,
    input  lc3b_set set,
    input  logic    tag0_hit,
    input  logic    tag1_hit,
    input  logic    valid0,
    input  logic    valid1,
    input  logic    dirty0,
    input  logic    dirty1,
    output logic    lru,
    output logic    data_load,
    output logic    data_sel,
    output logic    tag_load,
    output logic    valid_set,
    output logic    dirty_set,
    output logic    dirty_clear,
    output logic    pmem_read,
    output logic    pmem_write,
    input  logic    pmem_resp,
    output logic    pmem_addr_sel
);

    cache_state_t state_q;
    cache_state_t state_d;

    logic req;
    logic hit;
    logic victim_valid;
    logic victim_dirty;
    logic lru_we;
    logic lru_wdata;

    assign req = mem_read | mem_write;
    assign hit = tag0_hit | tag1_hit;

    // Status of the way the LRU bit currently names as victim.
    assign victim_valid = lru ? valid1 : valid0;
    assign victim_dirty = lru ? dirty1 : dirty0;

    // A hit on way0 makes way1 the next victim and vice versa; way0 takes
    // priority if both tags report a match.
    assign lru_wdata = tag0_hit ? 1'b1 : 1'b0;

    lru_array #(
        .NUM_SETS (NUM_SETS)
    ) u_lru_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (lru_we),
        .idx_i   (set),
        .wdata_i (lru_wdata),
        .rdata_o (lru)
    );

    always_comb begin
        state_d       = state_q;
        mem_resp      = 1'b0;
        data_load     = 1'b0;
        data_sel      = DSEL_CPU;
        tag_load      = 1'b0;
        valid_set     = 1'b0;
        dirty_set     = 1'b0;
        dirty_clear   = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = PADDR_CPU;
        lru_we        = 1'b0;

        // Strobes stay quiet for the whole time reset is held, even though
        // the state register already sits in IDLE.
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (req && hit) begin
                        mem_resp = 1'b1;
                        lru_we   = 1'b1;
                        if (mem_write) begin
                            data_load = 1'b1;
                            data_sel  = DSEL_CPU;
                            dirty_set = 1'b1;
                        end
                    end else if (req) begin
                        // Only a valid and dirty victim needs writing back.
                        if (victim_valid && victim_dirty) begin
                            state_d = WRITEBACK;
                        end else begin
                            state_d = ALLOCATE;
                        end
                    end
                    // pmem_resp arriving here is stray and ignored.
                end

                WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = PADDR_VICTIM;
                    if (pmem_resp) begin
                        dirty_clear = 1'b1;
                        state_d     = ALLOCATE;
                    end
                end

                ALLOCATE: begin
                    // Runs to completion even if the CPU drops its request.
                    pmem_read     = 1'b1;
                    pmem_addr_sel = PADDR_CPU;
                    if (pmem_resp) begin
                        data_load   = 1'b1;
                        data_sel    = DSEL_PMEM;
                        tag_load    = 1'b1;
                        valid_set   = 1'b1;
                        dirty_clear = 1'b1;
                        // The next IDLE cycle hits on the new line, completes
                        // the request and updates the LRU bit.
                        state_d     = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_cache_control.sv
module tb_cache_control;

    logic       clk;
    logic       rst;
    logic       mem_read;
    logic       mem_write;
    logic       mem_resp;
    logic [2:0] set;
    logic       tag0_hit;
    logic       tag1_hit;
    logic       valid0;
    logic       valid1;
    logic       dirty0;
    logic       dirty1;
    logic       lru;
    logic       data_load;
    logic       data_sel;
    logic       tag_load;
    logic       valid_set;
    logic       dirty_set;
    logic       dirty_clear;
    logic       pmem_read;
    logic       pmem_write;
    logic       pmem_resp;
    logic       pmem_addr_sel;

    cache_control #(.NUM_SETS(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_resp      (mem_resp),
        .set           (set),
        .tag0_hit      (tag0_hit),
        .tag1_hit      (tag1_hit),
        .valid0        (valid0),
        .valid1        (valid1),
        .dirty0        (dirty0),
        .dirty1        (dirty1),
        .lru           (lru),
        .data_load     (data_load),
        .data_sel      (data_sel),
        .tag_load      (tag_load),
        .valid_set     (valid_set),
        .dirty_set     (dirty_set),
        .dirty_clear   (dirty_clear),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_resp     (pmem_resp),
        .pmem_addr_sel (pmem_addr_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector bit positions:
    // {mem_resp, lru, data_load, data_sel, tag_load, valid_set,
    //  dirty_set, dirty_clear, pmem_read, pmem_write, pmem_addr_sel}
    localparam logic [10:0] E_RESP = 11'b100_0000_0000;
    localparam logic [10:0] E_LRU  = 11'b010_0000_0000;
    localparam logic [10:0] E_DL   = 11'b001_0000_0000;
    localparam logic [10:0] E_DS   = 11'b000_1000_0000;
    localparam logic [10:0] E_TL   = 11'b000_0100_0000;
    localparam logic [10:0] E_VS   = 11'b000_0010_0000;
    localparam logic [10:0] E_DSET = 11'b000_0001_0000;
    localparam logic [10:0] E_DCLR = 11'b000_0000_1000;
    localparam logic [10:0] E_PRD  = 11'b000_0000_0100;
    localparam logic [10:0] E_PWR  = 11'b000_0000_0010;
    localparam logic [10:0] E_PAS  = 11'b000_0000_0001;
    localparam logic [10:0] E_NONE = 11'b000_0000_0000;
    localparam logic [10:0] FILL   = E_PRD | E_DL | E_DS | E_TL | E_VS | E_DCLR;
    localparam logic [10:0] WB     = E_PWR | E_PAS;

    // Hit/status flags: {tag0_hit, tag1_hit, valid0, valid1, dirty0, dirty1}
    localparam logic [5:0] F_NONE   = 6'b000000;
    localparam logic [5:0] F_T0     = 6'b100000;
    localparam logic [5:0] F_T1V1   = 6'b010100;
    localparam logic [5:0] F_T1     = 6'b010000;
    localparam logic [5:0] F_BOTH   = 6'b110000;
    localparam logic [5:0] F_V1D1   = 6'b000101;
    localparam logic [5:0] F_T1V1D1 = 6'b010101;

    logic [10:0] exp_q[$];
    string       name_q[$];
    int          checks;
    int          errors;

    // Drive one cycle of stimulus just after the rising edge and record the
    // outputs that cycle must show.
    task automatic cyc(input logic r, input logic rd, input logic wr,
                       input logic [2:0] s, input logic [5:0] f,
                       input logic pr, input logic [10:0] e, input string nm);
        @(posedge clk);
        #1;
        rst       = r;
        mem_read  = rd;
        mem_write = wr;
        set       = s;
        tag0_hit  = f[5];
        tag1_hit  = f[4];
        valid0    = f[3];
        valid1    = f[2];
        dirty0    = f[1];
        dirty1    = f[0];
        pmem_resp = pr;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compares the DUT outputs against the scoreboard on the
    // falling edge of every cycle that has an expectation queued.
    initial begin
        logic [10:0] got;
        logic [10:0] want;
        string       nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                nm   = name_q.pop_front();
                got  = {mem_resp, lru, data_load, data_sel, tag_load, valid_set,
                        dirty_set, dirty_clear, pmem_read, pmem_write, pmem_addr_sel};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL %s: got %b expected %b (resp,lru,dl,ds,tl,vs,dset,dclr,prd,pwr,pas)",
                             nm, got, want);
                end
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        set       = 3'd0;
        tag0_hit  = 1'b0;
        tag1_hit  = 1'b0;
        valid0    = 1'b0;
        valid1    = 1'b0;
        dirty0    = 1'b0;
        dirty1    = 1'b0;
        pmem_resp = 1'b0;

        // Reset state: all strobes low, every LRU bit cleared.
        cyc(1, 0, 0, 3'd0, F_NONE, 0, E_NONE, "reset_hold");
        cyc(1, 0, 0, 3'd0, F_NONE, 0, E_NONE, "reset_hold");
        for (int s = 0; s < 8; s++) begin
            cyc(0, 0, 0, s[2:0], F_NONE, 0, E_NONE, "reset_lru");
        end

        // Read hit on way1, set 3.
        cyc(0, 1, 0, 3'd3, F_T1V1, 0, E_RESP, "rd_hit");
        cyc(0, 0, 0, 3'd3, F_NONE, 0, E_NONE, "rd_hit_lru");

        // Write hit on way0, set 5.
        cyc(0, 0, 1, 3'd5, F_T0, 0, E_RESP | E_DL | E_DSET, "wr_hit");
        cyc(0, 0, 0, 3'd5, F_NONE, 0, E_LRU, "wr_hit_lru");

        // Clean miss, set 2: four ALLOCATE cycles, then the completing hit.
        cyc(0, 1, 0, 3'd2, F_NONE, 0, E_NONE, "cm_enter");
        cyc(0, 1, 0, 3'd2, F_NONE, 0, E_PRD, "cm_hold");
        cyc(0, 1, 0, 3'd2, F_NONE, 0, E_PRD, "cm_hold");
        cyc(0, 1, 0, 3'd2, F_NONE, 0, E_PRD, "cm_hold");
        cyc(0, 1, 0, 3'd2, F_NONE, 1, FILL, "cm_fill");
        cyc(0, 1, 0, 3'd2, F_T0, 0, E_RESP, "cm_done");
        cyc(0, 0, 0, 3'd2, F_NONE, 0, E_LRU, "cm_lru");

        // Dirty miss, set 7: first make way1 the victim.
        cyc(0, 1, 0, 3'd7, F_T0, 0, E_RESP, "dm_pre_hit");
        cyc(0, 0, 1, 3'd7, F_V1D1, 0, E_LRU, "dm_enter");
        cyc(0, 0, 1, 3'd7, F_V1D1, 0, E_LRU | WB, "dm_wb_hold");
        cyc(0, 0, 1, 3'd7, F_V1D1, 0, E_LRU | WB, "dm_wb_hold");
        cyc(0, 0, 1, 3'd7, F_V1D1, 0, E_LRU | WB, "dm_wb_hold");
        cyc(0, 0, 1, 3'd7, F_V1D1, 1, E_LRU | WB | E_DCLR, "dm_wb_resp");
        cyc(0, 0, 1, 3'd7, F_V1D1, 0, E_LRU | E_PRD, "dm_al_hold");
        cyc(0, 0, 1, 3'd7, F_V1D1, 0, E_LRU | E_PRD, "dm_al_hold");
        cyc(0, 0, 1, 3'd7, F_V1D1, 1, E_LRU | FILL, "dm_fill");
        cyc(0, 0, 1, 3'd7, F_T1V1D1, 0, E_RESP | E_LRU | E_DL | E_DSET, "dm_done");
        cyc(0, 0, 0, 3'd7, F_NONE, 0, E_NONE, "dm_lru");

        // Reset during WRITEBACK (set 2 has lru = 1): strobes drop at once.
        cyc(0, 0, 1, 3'd2, F_V1D1, 0, E_LRU, "rst_wb_enter");
        cyc(0, 0, 1, 3'd2, F_V1D1, 0, E_LRU | WB, "rst_wb_hold");
        cyc(1, 0, 1, 3'd2, F_V1D1, 0, E_NONE, "rst_async");
        cyc(0, 0, 0, 3'd2, F_NONE, 1, E_NONE, "rst_lru2_stray_resp");
        cyc(0, 0, 0, 3'd5, F_NONE, 0, E_NONE, "rst_lru5");
        cyc(0, 1, 0, 3'd2, F_T1V1, 0, E_RESP, "rst_idle_hit");

        // Request dropped during ALLOCATE: burst still completes, LRU untouched.
        cyc(0, 1, 0, 3'd6, F_NONE, 0, E_NONE, "drop_enter");
        cyc(0, 0, 0, 3'd6, F_NONE, 0, E_PRD, "drop_hold");
        cyc(0, 0, 0, 3'd6, F_NONE, 0, E_PRD, "drop_hold");
        cyc(0, 0, 0, 3'd6, F_NONE, 1, FILL, "drop_fill");
        cyc(0, 0, 0, 3'd6, F_NONE, 0, E_NONE, "drop_idle");

        // Both tags hit: way0 wins.
        cyc(0, 1, 0, 3'd1, F_BOTH, 0, E_RESP, "both_hit");
        cyc(0, 0, 0, 3'd1, F_NONE, 0, E_LRU, "both_lru");

        // Read and write together behave as a write.
        cyc(0, 1, 1, 3'd0, F_T0, 0, E_RESP | E_DL | E_DSET, "rw_hit");
        cyc(0, 0, 0, 3'd0, F_NONE, 0, E_LRU, "rw_lru");
        cyc(0, 1, 1, 3'd0, F_T1, 0, E_RESP | E_LRU | E_DL | E_DSET, "rw_hit_w1");
        cyc(0, 0, 0, 3'd0, F_NONE, 0, E_NONE, "rw_lru_w1");

        // Let the monitor drain the scoreboard, with a bound.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
